// File: rtl/song_fetcher.sv
// rtl/song_fetcher.sv - song ROM word fetcher feeding the note arranger
//
// Purpose: walks the selected song in the external synchronous ROM, hands
// each word to the note arranger with a one-cycle strobe, and waits for the
// arranger's acknowledgement before fetching the next word. It gates issue
// on play, detects end of song, and drops note words that would exceed
// three notes in one chord.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   play          level; 1 = issue words, 0 = stop issuing new words
//   song          song select, sampled only when leaving IDLE
//   rom_addr      ROM address {song, index}, updated from registers only
//   rom_data      ROM output, valid one cycle after rom_addr
//   note_to_load  word presented to the arranger
//   load_new_note one-cycle strobe: note_to_load valid
//   note_done     one-cycle acknowledgement from the arranger
//   song_done     end-of-song indication
//   overflow      sticky: a note word was dropped
//
// Build option: SONG_FETCHER_LOOP_EN makes the song repeat forever, with
// song_done pulsing for one cycle at each restart.

module song_fetcher #(
  parameter int SONG_BITS  = 2,
  parameter int INDEX_BITS = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic [SONG_BITS-1:0]            song,
  output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
  input  logic [15:0]                     rom_data,
  output logic [15:0]                     note_to_load,
  output logic                            load_new_note,
  input  logic                            note_done,
  output logic                            song_done,
  output logic                            overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DATA, S_STROBE, S_WAIT, S_PAUSED, S_DONE
  } state_t;

  state_t                  state, state_nx;
  logic [SONG_BITS-1:0]    song_q, song_q_nx;
  logic [INDEX_BITS-1:0]   index, index_nx;
  logic [1:0]              group, group_nx;
  logic [1:0]              group_inc;
  logic [15:0]             note_nx;
  logic                    overflow_nx;
  logic                    song_done_nx;
  logic                    end_song;
  logic                    is_end;
  logic                    is_note;
  logic                    last_index;

  // Address registers change on the edge that enters FETCH, so the ROM sees
  // a stable address during FETCH and its registered data is valid in DATA.
  assign rom_addr      = {song_q, index};
  assign load_new_note = (state == S_STROBE);

  assign is_end     = rom_data[15] && (rom_data[8:3] == 6'd0);
  assign is_note    = ~rom_data[15];
  assign last_index = &index;
  assign group_inc  = (group == 2'd3) ? 2'd3 : group + 2'd1;

  always_comb begin
    state_nx     = state;
    song_q_nx    = song_q;
    index_nx     = index;
    group_nx     = group;
    note_nx      = note_to_load;
    overflow_nx  = overflow;
    song_done_nx = 1'b0;
    end_song     = 1'b0;

    case (state)
      S_IDLE: begin
        if (play) begin
          song_q_nx   = song;
          index_nx    = '0;
          group_nx    = 2'd0;
          overflow_nx = 1'b0;
          state_nx    = S_FETCH;
        end
      end
      S_FETCH: state_nx = S_DATA;
      S_DATA: begin
        if (is_end) begin
          end_song = 1'b1;
        end else if (is_note && (group == 2'd3)) begin
          // Fourth note of a chord: skip it without disturbing the arranger.
          overflow_nx = 1'b1;
          index_nx    = index + INDEX_BITS'(1);
          if (last_index) end_song = 1'b1;
          else            state_nx = play ? S_FETCH : S_PAUSED;
        end else begin
          note_nx  = rom_data;
          state_nx = S_STROBE;
        end
      end
      S_STROBE: state_nx = S_WAIT;
      S_WAIT: begin
        if (note_done) begin
          index_nx = index + INDEX_BITS'(1);
          // note_to_load still holds the acknowledged word.
          group_nx = note_to_load[15] ? 2'd0 : group_inc;
          if (last_index) end_song = 1'b1;
          else            state_nx = play ? S_FETCH : S_PAUSED;
        end
      end
      S_PAUSED: if (play) state_nx = S_FETCH;
      S_DONE:   if (!play) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

`ifdef SONG_FETCHER_LOOP_EN
    if (end_song) begin
      index_nx     = '0;
      group_nx     = 2'd0;
      song_done_nx = 1'b1;
      state_nx     = play ? S_FETCH : S_PAUSED;
    end
`else
    if (end_song) state_nx = S_DONE;
    song_done_nx = (state_nx == S_DONE);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      song_q       <= '0;
      index        <= '0;
      group        <= 2'd0;
      note_to_load <= 16'h0000;
      overflow     <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      state        <= state_nx;
      song_q       <= song_q_nx;
      index        <= index_nx;
      group        <= group_nx;
      note_to_load <= note_nx;
      overflow     <= overflow_nx;
      song_done    <= song_done_nx;
    end
  end

endmodule

// File: doc/song_fetcher.md
# song_fetcher

Front end of the note pipeline: reads 16-bit song words from the external synchronous song ROM, presents them to the note arranger one at a time, and advances only after the arranger's `note_done` acknowledgement. It owns song addressing, the play/pause gating of word issue, end-of-song detection, and suppression of chord overflow (more than three notes before a time-advance word).

## Interface
Parameters:
- SONG_BITS, 2, song-select width (number of songs = 2^SONG_BITS)
- INDEX_BITS, 7, word-index width within a song (words per song = 2^INDEX_BITS)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- play  input  1  level; 1 = issue words, 0 = stop issuing new words
- song  input  SONG_BITS  song select, sampled only in IDLE
- rom_addr  output  SONG_BITS+INDEX_BITS  registered ROM address {song_q, index}
- rom_data  input  16  ROM output, valid one cycle after rom_addr
- note_to_load  output  16  registered word presented to arranger
- load_new_note  output  1  one-cycle strobe: note_to_load valid
- note_done  input  1  one-cycle acknowledgement from arranger
- song_done  output  1  end-of-song indication
- overflow  output  1  sticky: a note word was dropped

## Operation
- Word format: bit15=0 → note ({[14:9] pitch, [8:3] duration, [2] stereo}); bit15=1 → time advance, [8:3] = duration in beats. End marker: bit15=1 with [8:3]=0.
- States: IDLE, FETCH, DATA, STROBE, WAIT, PAUSED, DONE. Reset → IDLE.
- IDLE: song_q←song, index←0, group←0, overflow←0 when play=1; then FETCH. Else stay.
- FETCH: rom_addr←{song_q,index}; → DATA.
- DATA: word←rom_data (capture). End marker → DONE. Note word with group=3 → drop: overflow←1, index+1 (wrap → DONE), → FETCH if play else PAUSED. Otherwise note_to_load←word, → STROBE.
- STROBE: load_new_note=1 exactly this cycle; → WAIT. Strobe is never repeated for the same word.
- WAIT: hold until note_done=1. Then index+1; group←group+1 for a note word, group←0 for an advance word. Index was 2^INDEX_BITS−1 → DONE; else → FETCH if play=1, else PAUSED.
- PAUSED: → FETCH when play=1.
- DONE: song_done=1; → IDLE when play=0.
- note_done outside WAIT: ignored. play falling during WAIT: acknowledgement still accepted, then PAUSED.
- group is 2 bits, saturates at 3.

## Timing
- Reset values: rom_addr=0, note_to_load=0, load_new_note=0, song_done=0, overflow=0, state IDLE.
- Start: play rises at cycle 0 (IDLE) → FETCH cycle 1, DATA 2, load_new_note high cycle 3.
- Arranger acknowledges one cycle after the strobe; note_done sampled in WAIT at cycle 4 → next FETCH 5, next strobe cycle 7. Minimum strobe spacing: 4 cycles.
- Advance words: WAIT persists for the full duration until arranger's note_done.
- note_to_load holds its value between strobes; changes only on DATA capture.
- Drop path: DATA → FETCH with no strobe; 2 cycles per dropped word.
- Reset asserted mid-operation: all outputs to reset values immediately (async), no pending strobe survives.

## Configuration
- SONG_FETCHER_LOOP_EN defined: end marker or index wrap → index←0, group←0, song_done pulses high one cycle, → FETCH (or PAUSED if play=0); song repeats indefinitely.
- Undefined: behaviour as above (DONE, song_done held until play=0).

## Test plan
- Reset, ROM {16'h1A48, 16'h8018, end}, play=1, arranger model acks 1 cycle after each strobe → strobes at cycles 3 and 7 with note_to_load 16'h1A48 then 16'h8018, then song_done=1, rom_addr final index 2.
- Four consecutive note words then advance word → three strobes, fourth dropped, overflow=1, advance word strobed next; overflow clears on next IDLE→play.
- play dropped during WAIT of an advance word, note_done arrives → no further strobe; play=1 again → FETCH next cycle, strobe 2 cycles later.
- Spurious note_done during FETCH/DATA/PAUSED → no index change, no strobe.
- Song of 128 non-terminal notes with acks → index wraps, song_done=1 (LOOP_EN: song_done pulse, rom_addr returns to {song,0}).
- reset=0 asserted the cycle load_new_note is high → load_new_note=0 immediately, rom_addr=0, state IDLE after release.
